jogo_unidade_controle: RTL and testbench
========================================

# jogo_unidade_controle

Control unit that sequences the game datapath: the level counters, the score counter and the game-time budget. It latches the difficulty level at game start, runs a preparation countdown, then enables only the active level's counter on every game tick. It issues the synchronous clears for the level counters and the score counter, and ends the game on timeout or on reaching the target score. It sits between the top-level input conditioning (start/pause buttons, 1 kHz tick) and the game datapath's `conta_*`/`reset_*` control inputs.

## Interface
- `PREP_TICKS`, default 3000: ticks spent in PREPARA before play starts.
- `TEMPO_JOGO`, default 60000: game-time budget in ticks.
- `SCORE_MAX`, default 999: score that ends the game as a win.
- `TEMPO_N`, default 16: width of the time counters.
- `clock`, input, 1: system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `iniciar`, input, 1: start request, one-cycle pulse (already debounced).
- `pausar`, input, 1: pause request, level-sensitive.
- `tick`, input, 1: one-cycle game time-base enable (1 kHz).
- `nivel_dificuldade`, input, 2: level selector, sampled only in ZERA.
- `ganhou_ponto`, input, 1: point-won strobe from the datapath.
- `perdeu_ponto`, input, 1: point-lost strobe from the datapath.
- `pontuacao`, input, 10: current score from the datapath.
- `conta_nivel0`, output, 1: count enable for the level-0 counter.
- `conta_nivel1`, output, 1: count enable for the level-1 counter.
- `conta_nivel23`, output, 1: count enable for the level-2/3 counter.
- `reset_ponto`, output, 1: synchronous clear of the score counter.
- `reset_nivel0`, output, 1: synchronous clear of the level-0 counter.
- `reset_nivel1`, output, 1: synchronous clear of the level-1 counter.
- `reset_nivel23`, output, 1: synchronous clear of the level-2/3 counter.
- `nivel_travado`, output, 2: level latched for the current game.
- `tempo_restante`, output, TEMPO_N: remaining game ticks.
- `fim_jogo`, output, 1: high while in state FIM.
- `venceu`, output, 1: high in FIM when the game ended by reaching SCORE_MAX.
- `estado`, output, 3: current state encoding (debug).

## Operation
- **States:** IDLE, ZERA, PREPARA, JOGANDO, PONTO, PAUSA, FIM.
- **IDLE:** on `iniciar` go to ZERA.
- **ZERA:** lasts one cycle.
  - Assert `reset_ponto` and all three `reset_nivel*`.
  - Latch `nivel_travado <= nivel_dificuldade`.
  - Load the prep counter with PREP_TICKS and `tempo_restante` with TEMPO_JOGO.
  - Clear `venceu`, then go to PREPARA.
- **PREPARA:** decrement the prep counter on each `tick`. When a tick is seen with the counter at 1, go to JOGANDO. No `conta_*` is asserted.
- **JOGANDO:** the conta output selected by `nivel_travado` follows `tick`, and the other two conta outputs stay 0.
  - Mapping: 0 → `conta_nivel0`, 1 → `conta_nivel1`, 2 or 3 → `conta_nivel23`.
  - `tempo_restante` decrements on each `tick`.
- **Exit priority out of JOGANDO**, evaluated each cycle, highest first:
  1. `pontuacao >= SCORE_MAX`: go to FIM with `venceu=1`.
  2. `tick` while `tempo_restante == 1`: go to FIM with `venceu=0`.
  3. `ganhou_ponto | perdeu_ponto`: go to PONTO.
  4. `pausar`: go to PAUSA.
- **PONTO:** lasts one cycle.
  - Assert `reset_nivel*` for the latched level only.
  - `tick` still decrements `tempo_restante`; a timeout reached here goes to FIM.
  - Otherwise return to JOGANDO.
- **PAUSA:** all conta outputs 0 and the timers frozen. Return to JOGANDO when `pausar` falls.
- **FIM:** `fim_jogo=1`. Outputs hold. On `iniciar` go to ZERA.
- **Ignored inputs:** `iniciar` outside IDLE/FIM is ignored. Changes on `nivel_dificuldade` mid-game are ignored.
- **Zero budgets:** PREP_TICKS=0 or TEMPO_JOGO=0 is treated as 1.

## Timing
- **Reset values:** all outputs 0, `estado`=IDLE, timers 0.
- **Reset mid-game:** returns immediately to IDLE with every output cleared.
- **Registered outputs:** `reset_*`, `nivel_travado`, `tempo_restante`, `fim_jogo`, `venceu`, `estado`.
- **Combinational outputs:** `conta_*` = (state==JOGANDO) & `tick` & level match. This gives zero-cycle latency from `tick`.
- **ZERA clears:** the `reset_*` pulses are exactly one cycle, in the cycle after `iniciar` is sampled.
- **PONTO clear:** the level-counter clear is one cycle, starting the cycle after the point strobe.
- **Play start:** the first `conta_*` pulse can occur no earlier than the first `tick` after entering JOGANDO.
- **Simultaneous events:** a point strobe together with a timeout goes to FIM. The datapath still applies that point.

## Configuration
- **`JOGO_PAUSA_EN` defined:** PAUSA state and `pausar` handling are present as described above.
- **`JOGO_PAUSA_EN` undefined:** PAUSA is removed and `pausar` is ignored. JOGANDO leaves only via FIM or PONTO.

## Structure
- **Package `jogo_pkg`:** state enumeration `estado_t` (3-bit) and level constants NIVEL_0..NIVEL_3.
- **Sub-module `contador_tempo_jogo`:** loadable down counter with a tick enable and a hold input, producing the value and an `um` (==1) flag. Instantiated twice: prep timer and game timer.

## Test plan
- **Reset and start:** release `reset`, pulse `iniciar` with `nivel_dificuldade`=1 → one-cycle pulse on all four `reset_*`; `nivel_travado`=1; `tempo_restante`=60000.
- **Prep countdown:** PREP_TICKS=3, TEMPO_JOGO=10, level 0, 3 ticks → JOGANDO. The next 5 ticks give 5 `conta_nivel0` pulses, no `conta_nivel1`/`conta_nivel23` pulses, and `tempo_restante`=5.
- **Point in level 2:** `ganhou_ponto` strobe while in JOGANDO → one-cycle `reset_nivel23` in the next cycle only, then back to JOGANDO.
- **Timeout:** TEMPO_JOGO=10, 10 ticks with no points → FIM, `venceu`=0, `fim_jogo`=1.
- **Win:** `pontuacao`=999 → FIM next cycle with `venceu`=1, even when a `tick` arrives in the same cycle.
- **Pause (`JOGO_PAUSA_EN`):** `pausar` held for 20 ticks → no `conta_*` pulses and `tempo_restante` unchanged; play resumes after `pausar` falls.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared types for the game control unit.
// State encoding and difficulty level constants.
package jogo_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ZERA    = 3'd1,
      PREPARA = 3'd2,
      JOGANDO = 3'd3,
      PONTO   = 3'd4,
      PAUSA   = 3'd5,
      FIM     = 3'd6
   } estado_t;

   localparam logic [1:0] NIVEL_0 = 2'd0;
   localparam logic [1:0] NIVEL_1 = 2'd1;
   localparam logic [1:0] NIVEL_2 = 2'd2;
   localparam logic [1:0] NIVEL_3 = 2'd3;

endpackage

// File: rtl/contador_tempo_jogo.sv
// Loadable down counter with tick enable and hold.
// Saturates at zero; um flags a value of exactly one.
module contador_tempo_jogo #(
   parameter int N = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carrega,
   input  logic [N-1:0] carga,
   input  logic         tick,
   input  logic         segura,
   output logic [N-1:0] valor,
   output logic         um
);

   logic [N-1:0] valor_q;
   logic [N-1:0] valor_d;

   always_comb begin
      valor_d = valor_q;
      if (carrega)
         valor_d = carga;
      else if (tick && !segura && valor_q != '0)
         valor_d = valor_q - N'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) valor_q <= '0;
      else        valor_q <= valor_d;
   end

   assign valor = valor_q;
   assign um    = (valor_q == N'(1));

endmodule

// File: rtl/jogo_unidade_controle.sv
// Game control unit: level latch, prep countdown, play/point/end sequencing.
// Optional pause state enabled by defining JOGO_PAUSA_EN.
module jogo_unidade_controle
   import jogo_pkg::*;
#(
   parameter int PREP_TICKS = 3000,
   parameter int TEMPO_JOGO = 60000,
   parameter int SCORE_MAX  = 999,
   parameter int TEMPO_N    = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               pausar,
   input  logic               tick,
   input  logic [1:0]         nivel_dificuldade,
   input  logic               ganhou_ponto,
   input  logic               perdeu_ponto,
   input  logic [9:0]         pontuacao,
   output logic               conta_nivel0,
   output logic               conta_nivel1,
   output logic               conta_nivel23,
   output logic               reset_ponto,
   output logic               reset_nivel0,
   output logic               reset_nivel1,
   output logic               reset_nivel23,
   output logic [1:0]         nivel_travado,
   output logic [TEMPO_N-1:0] tempo_restante,
   output logic               fim_jogo,
   output logic               venceu,
   output logic [2:0]         estado
);

   // Zero budgets would never reach the ==1 exit condition
   localparam int PREP_EF  = (PREP_TICKS == 0) ? 1 : PREP_TICKS;
   localparam int TEMPO_EF = (TEMPO_JOGO == 0) ? 1 : TEMPO_JOGO;

   estado_t      state_q, state_d;
   logic [1:0]   nivel_q, nivel_d;
   logic         venceu_q, venceu_d;
   logic         fim_q;
   logic [3:0]   rst_q, rst_d;
   logic         sel0, sel1, sel23;
   logic         prep_um, tempo_um, vitoria;
   logic [TEMPO_N-1:0] prep_unused;

`ifndef JOGO_PAUSA_EN
   logic unused_pausar;
   assign unused_pausar = pausar;
`endif

   always_comb begin
      sel0  = 1'b0;
      sel1  = 1'b0;
      sel23 = 1'b0;
      unique case (1'b1)
         (nivel_q == NIVEL_0): sel0  = 1'b1;
         (nivel_q == NIVEL_1): sel1  = 1'b1;
         default:              sel23 = 1'b1;
      endcase
   end

   contador_tempo_jogo #(.N(TEMPO_N)) u_prep (
      .clock   (clock),
      .reset   (reset),
      .carrega (state_q == ZERA),
      .carga   (TEMPO_N'(PREP_EF)),
      .tick    (tick),
      .segura  (state_q != PREPARA),
      .valor   (prep_unused),
      .um      (prep_um)
   );

   contador_tempo_jogo #(.N(TEMPO_N)) u_tempo (
      .clock   (clock),
      .reset   (reset),
      .carrega (state_q == ZERA),
      .carga   (TEMPO_N'(TEMPO_EF)),
      .tick    (tick),
      .segura  (!(state_q == JOGANDO || state_q == PONTO)),
      .valor   (tempo_restante),
      .um      (tempo_um)
   );

   assign vitoria = (pontuacao >= 10'(SCORE_MAX));

   always_comb begin
      state_d  = state_q;
      nivel_d  = nivel_q;
      venceu_d = venceu_q;
      unique case (state_q)
         IDLE:    if (iniciar) state_d = ZERA;
         ZERA: begin
            nivel_d  = nivel_dificuldade;
            venceu_d = 1'b0;
            state_d  = PREPARA;
         end
         PREPARA: if (tick && prep_um) state_d = JOGANDO;
         JOGANDO: begin
            if (vitoria) begin
               state_d  = FIM;
               venceu_d = 1'b1;
            end else if (tick && tempo_um)
               state_d = FIM;
            else if (ganhou_ponto || perdeu_ponto)
               state_d = PONTO;
`ifdef JOGO_PAUSA_EN
            else if (pausar)
               state_d = PAUSA;
`endif
         end
         PONTO:   state_d = (tick && tempo_um) ? FIM : JOGANDO;
`ifdef JOGO_PAUSA_EN
         PAUSA:   if (!pausar) state_d = JOGANDO;
`endif
         FIM:     if (iniciar) state_d = ZERA;
         default: state_d = IDLE;
      endcase
   end

   // Clears are registered from the next state so they line up with it
   always_comb begin
      rst_d    = 4'b0000;
      rst_d[3] = (state_d == ZERA);
      rst_d[2] = (state_d == ZERA) || (state_d == PONTO && sel0);
      rst_d[1] = (state_d == ZERA) || (state_d == PONTO && sel1);
      rst_d[0] = (state_d == ZERA) || (state_d == PONTO && sel23);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         nivel_q  <= NIVEL_0;
         venceu_q <= 1'b0;
         fim_q    <= 1'b0;
         rst_q    <= 4'b0000;
      end else begin
         state_q  <= state_d;
         nivel_q  <= nivel_d;
         venceu_q <= venceu_d;
         fim_q    <= (state_d == FIM);
         rst_q    <= rst_d;
      end
   end

   assign conta_nivel0  = (state_q == JOGANDO) && tick && sel0;
   assign conta_nivel1  = (state_q == JOGANDO) && tick && sel1;
   assign conta_nivel23 = (state_q == JOGANDO) && tick && sel23;

   assign reset_ponto   = rst_q[3];
   assign reset_nivel0  = rst_q[2];
   assign reset_nivel1  = rst_q[1];
   assign reset_nivel23 = rst_q[0];
   assign nivel_travado = nivel_q;
   assign fim_jogo      = fim_q;
   assign venceu        = venceu_q;
   assign estado        = state_q;

endmodule

// File: tb/tb_jogo_unidade_controle.sv
// Directed bench for jogo_unidade_controle (PREP_TICKS=3, TEMPO_JOGO=10).
// Pause checks follow JOGO_PAUSA_EN.
module tb_jogo_unidade_controle;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iniciar, pausar, tick, ganhou, perdeu;
   logic [1:0]  nivel;
   logic [9:0]  pont;
   logic        c0, c1, c23;
   logic        rp, r0, r1, r23;
   logic [1:0]  ntrav;
   logic [15:0] tempo;
   logic        fim, venc;
   logic [2:0]  est;

   int n_tests = 0;
   int n_fail  = 0;
   int k0 = 0, k1 = 0, k23 = 0;
   int b0, b1, b23;

   always #5 clk = ~clk;

   jogo_unidade_controle #(.PREP_TICKS(3), .TEMPO_JOGO(10)) dut (
      .clock             (clk),
      .reset             (rst_n),
      .iniciar           (iniciar),
      .pausar            (pausar),
      .tick              (tick),
      .nivel_dificuldade (nivel),
      .ganhou_ponto      (ganhou),
      .perdeu_ponto      (perdeu),
      .pontuacao         (pont),
      .conta_nivel0      (c0),
      .conta_nivel1      (c1),
      .conta_nivel23     (c23),
      .reset_ponto       (rp),
      .reset_nivel0      (r0),
      .reset_nivel1      (r1),
      .reset_nivel23     (r23),
      .nivel_travado     (ntrav),
      .tempo_restante    (tempo),
      .fim_jogo          (fim),
      .venceu            (venc),
      .estado            (est)
   );

   always @(negedge clk) begin
      if (c0  === 1'b1) k0++;
      if (c1  === 1'b1) k1++;
      if (c23 === 1'b1) k23++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
   endtask

   task automatic snap();
      b0 = k0;
      b1 = k1;
      b23 = k23;
   endtask

   task automatic start(input logic [1:0] lv);
      nivel = lv;
      iniciar = 1'b1;
      cyc();
      iniciar = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      {iniciar, pausar, tick, ganhou, perdeu} = '0;
      nivel = 2'd0;
      pont  = 10'd0;
      repeat (3) cyc();
      chk("rst_estado", 32'(est), 32'd0);
      chk("rst_outs", {rp, r0, r1, r23, fim, venc, c0, c1, c23}, 32'd0);
      chk("rst_tempo", 32'(tempo), 32'd0);
      chk("rst_nivel", 32'(ntrav), 32'd0);
      rst_n = 1'b1;
      cyc();
      chk("idle", 32'(est), 32'd0);

      // game 1: level 1, timeout
      start(2'd1);
      chk("zera_estado", 32'(est), 32'd1);
      chk("zera_resets", {rp, r0, r1, r23}, 32'hF);
      cyc();
      chk("prep_estado", 32'(est), 32'd2);
      chk("prep_resets", {rp, r0, r1, r23}, 32'h0);
      chk("prep_nivel", 32'(ntrav), 32'd1);
      chk("prep_tempo", 32'(tempo), 32'd10);
      snap();
      do_tick();
      do_tick();
      chk("prep_2ticks", 32'(est), 32'd2);
      do_tick();
      chk("jogando", 32'(est), 32'd3);
      chk("prep_noconta", k0 + k1 + k23 - b0 - b1 - b23, 32'd0);
      snap();
      for (int i = 0; i < 5; i++) do_tick();
      chk("g1_conta1", k1 - b1, 32'd5);
      chk("g1_other", (k0 - b0) + (k23 - b23), 32'd0);
      chk("g1_tempo5", 32'(tempo), 32'd5);
      for (int i = 0; i < 4; i++) do_tick();
      chk("g1_pre_to", 32'(est), 32'd3);
      do_tick();
      chk("to_estado", 32'(est), 32'd6);
      chk("to_fim", 32'(fim), 32'd1);
      chk("to_venceu", 32'(venc), 32'd0);
      chk("to_tempo", 32'(tempo), 32'd0);
      cyc();
      chk("fim_hold", {est, fim}, {3'd6, 1'b1});

      // game 2: level 2, point, ignored inputs, pause, win
      start(2'd2);
      chk("g2_zera", 32'(est), 32'd1);
      cyc();
      for (int i = 0; i < 3; i++) do_tick();
      chk("g2_jogando", 32'(est), 32'd3);
      snap();
      do_tick();
      do_tick();
      chk("g2_conta23", k23 - b23, 32'd2);
      chk("g2_tempo8", 32'(tempo), 32'd8);
      ganhou = 1'b1;
      cyc();
      ganhou = 1'b0;
      chk("ponto_estado", 32'(est), 32'd4);
      chk("ponto_resets", {rp, r0, r1, r23}, 32'h1);
      cyc();
      chk("ponto_back", 32'(est), 32'd3);
      chk("ponto_clr", {rp, r0, r1, r23}, 32'h0);
      iniciar = 1'b1;
      nivel = 2'd0;
      cyc();
      iniciar = 1'b0;
      chk("ini_ignored", {est, rp}, {3'd3, 1'b0});
      chk("nivel_hold", 32'(ntrav), 32'd2);
      snap();
      do_tick();
      chk("nivel_hold_c", {k0 - b0, k23 - b23}, {32'd0, 32'd1});
      chk("g2_tempo7", 32'(tempo), 32'd7);
      snap();
`ifdef JOGO_PAUSA_EN
      pausar = 1'b1;
      cyc();
      chk("pausa_estado", 32'(est), 32'd5);
      for (int i = 0; i < 20; i++) do_tick();
      chk("pausa_conta", k0 + k1 + k23 - b0 - b1 - b23, 32'd0);
      chk("pausa_tempo", 32'(tempo), 32'd7);
      pausar = 1'b0;
      cyc();
      chk("pausa_resume", 32'(est), 32'd3);
      do_tick();
      chk("resume_conta", k23 - b23, 32'd1);
`else
      pausar = 1'b1;
      do_tick();
      chk("nopausa_estado", 32'(est), 32'd3);
      chk("nopausa_conta", k23 - b23, 32'd1);
      pausar = 1'b0;
`endif
      chk("g2_tempo6", 32'(tempo), 32'd6);
      pont = 10'd999;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("win_estado", 32'(est), 32'd6);
      chk("win_venceu", {fim, venc}, 32'd3);
      pont = 10'd0;
      cyc();
      cyc();
      chk("win_hold", {est, fim, venc}, {3'd6, 2'b11});

      // game 3: level 0, point coinciding with timeout
      start(2'd0);
      cyc();
      chk("g3_venceu_clr", {est, fim, venc}, {3'd2, 2'b00});
      for (int i = 0; i < 3; i++) do_tick();
      snap();
      for (int i = 0; i < 9; i++) do_tick();
      chk("g3_conta0", k0 - b0, 32'd9);
      chk("g3_tempo1", 32'(tempo), 32'd1);
      ganhou = 1'b1;
      tick = 1'b1;
      cyc();
      ganhou = 1'b0;
      tick = 1'b0;
      chk("sim_estado", 32'(est), 32'd6);
      chk("sim_venceu", {venc, r0}, 32'd0);

      // game 4: asynchronous reset mid-game
      start(2'd3);
      cyc();
      chk("g4_prep", 32'(est), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("arst_estado", 32'(est), 32'd0);
      chk("arst_outs", {rp, r0, r1, r23, fim, venc, ntrav}, 32'd0);
      chk("arst_tempo", 32'(tempo), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
